// File: rtl/axi_sim_mem_pkg.sv
// rtl/axi_sim_mem_pkg.sv - burst/response constants, FSM states and address stepping for axi_sim_mem
package axi_sim_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_e;

  // WRAP bursts only make sense for power-of-two beat counts of 2..16
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Address of the following beat; computed at 64 bits so any ADDR_WIDTH fits.
  // Illegal WRAP lengths and the reserved encoding step like INCR.
  function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                            input logic [2:0]  size,
                                            input logic [7:0]  len,
                                            input logic [1:0]  burst);
    logic [63:0] step;
    logic [63:0] span_mask;
    step      = 64'd1 << size;
    span_mask = ((64'(len) + 64'd1) << size) - 64'd1;
    if (burst == BURST_FIXED) begin
      return addr;
    end
    if ((burst == BURST_WRAP) && wrap_len_ok(len)) begin
      return (addr & ~span_mask) | ((addr + step) & span_mask);
    end
    return addr + step;
  endfunction

endpackage

// File: rtl/axi_sim_mem_addr_gen.sv
// rtl/axi_sim_mem_addr_gen.sv - per-channel beat counter, address stepping and burst error flag
module axi_sim_mem_addr_gen
  import axi_sim_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 4096,
  localparam int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [7:0]            start_len,
  input  logic [2:0]            start_size,
  input  logic [1:0]            start_burst,
  input  logic                  advance,
  output logic [IDX_W-1:0]      word_idx,
  output logic                  last,
  output logic                  in_range,
  output logic                  cfg_err
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] addr_q, addr_v;
  logic [7:0]            cnt_q, cnt_v;
  logic [7:0]            len_q, len_v;
  logic [2:0]            size_q, size_v;
  logic [1:0]            burst_q, burst_v;
  logic                  err_q, err_v;
  logic                  start_err;

  // Whole-burst errors: oversize beats, reserved burst type, illegal WRAP length
  always_comb begin
    start_err = (start_size > 3'(BYTE_SHIFT)) ||
                (start_burst == 2'b11) ||
                ((start_burst == BURST_WRAP) && !wrap_len_ok(start_len));
  end

  // Current beat view; on the start cycle the request fields are used directly so a
  // zero-wait fetch can happen in the same cycle as the address handshake
  always_comb begin
    if (start) begin
      addr_v  = start_addr;
      cnt_v   = 8'd0;
      len_v   = start_len;
      size_v  = start_size;
      burst_v = start_burst;
      err_v   = start_err;
    end else begin
      addr_v  = addr_q;
      cnt_v   = cnt_q;
      len_v   = len_q;
      size_v  = size_q;
      burst_v = burst_q;
      err_v   = err_q;
    end
  end

  assign in_range = (64'(addr_v) >> BYTE_SHIFT) < 64'(MEM_WORDS);
  assign word_idx = IDX_W'(64'(addr_v) >> BYTE_SHIFT);
  assign last     = (cnt_v == len_v);
  assign cfg_err  = err_v;

  // Latch the burst on start and step address/counter on every consumed beat
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      cnt_q   <= 8'd0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      if (start) begin
        len_q   <= start_len;
        size_q  <= start_size;
        burst_q <= start_burst;
        err_q   <= start_err;
      end
      if (advance) begin
        addr_q <= ADDR_WIDTH'(next_addr(64'(addr_v), size_v, len_v, burst_v));
        cnt_q  <= cnt_v + 8'd1;
      end else if (start) begin
        addr_q <= start_addr;
        cnt_q  <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/axi_sim_mem.sv
// rtl/axi_sim_mem.sv - behavioural AXI4 slave memory, one write and one read burst in flight
module axi_sim_mem
  import axi_sim_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int ID_WIDTH     = 1,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  wr_state_e        wr_state, wr_next;
  logic             w_start, w_beat, wr_err_q, beat_err;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_last, wr_in_range, wr_cfg_err;

  rd_state_e        rd_state, rd_next;
  logic             r_start, r_fetch;
  logic [LAT_W-1:0] lat_cnt;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_last, rd_in_range, rd_cfg_err;

  axi_sim_mem_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_wr_ag (
    .clk         (clk),
    .rst         (rst),
    .start       (w_start),
    .start_addr  (s_axi_awaddr),
    .start_len   (s_axi_awlen),
    .start_size  (s_axi_awsize),
    .start_burst (s_axi_awburst),
    .advance     (w_beat),
    .word_idx    (wr_idx),
    .last        (wr_last),
    .in_range    (wr_in_range),
    .cfg_err     (wr_cfg_err)
  );

  axi_sim_mem_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_rd_ag (
    .clk         (clk),
    .rst         (rst),
    .start       (r_start),
    .start_addr  (s_axi_araddr),
    .start_len   (s_axi_arlen),
    .start_size  (s_axi_arsize),
    .start_burst (s_axi_arburst),
    .advance     (r_fetch),
    .word_idx    (rd_idx),
    .last        (rd_last),
    .in_range    (rd_in_range),
    .cfg_err     (rd_cfg_err)
  );

  // A beat is bad if out of range, part of a malformed burst, or wlast disagrees with the counter
  assign beat_err = !wr_in_range || wr_cfg_err || (s_axi_wlast != wr_last);

  // Write FSM next state and handshake outputs; everything held low while rst is high
  always_comb begin
    wr_next       = wr_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    w_start       = 1'b0;
    w_beat        = 1'b0;
    if (!rst) begin
      case (wr_state)
        W_IDLE: begin
          s_axi_awready = 1'b1;
          if (s_axi_awvalid) begin
            w_start = 1'b1;
            wr_next = W_DATA;
          end
        end
        W_DATA: begin
          s_axi_wready = 1'b1;
          if (s_axi_wvalid) begin
            w_beat = 1'b1;
            if (wr_last) begin
              wr_next = W_RESP;
            end
          end
        end
        W_RESP: begin
          s_axi_bvalid = 1'b1;
          s_axi_bresp  = wr_err_q ? RESP_SLVERR : RESP_OKAY;
          if (s_axi_bready) begin
            wr_next = W_IDLE;
          end
        end
        default: wr_next = W_IDLE;
      endcase
    end
  end

  // Write FSM state, echoed ID and sticky burst error
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      wr_err_q  <= 1'b0;
      s_axi_bid <= '0;
    end else begin
      wr_state <= wr_next;
      if (w_start) begin
        s_axi_bid <= s_axi_awid;
        wr_err_q  <= 1'b0;
      end else if (w_beat && beat_err) begin
        wr_err_q <= 1'b1;
      end
    end
  end

  // Byte-strobed array write; contents survive reset
  always_ff @(posedge clk) begin
    if (w_beat && wr_in_range && !wr_cfg_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[wr_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read FSM next state; r_fetch loads the next beat into the output registers
  always_comb begin
    rd_next       = rd_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    r_start       = 1'b0;
    r_fetch       = 1'b0;
    if (!rst) begin
      case (rd_state)
        R_IDLE: begin
          s_axi_arready = 1'b1;
          if (s_axi_arvalid) begin
            r_start = 1'b1;
            if (READ_LATENCY <= 1) begin
              r_fetch = 1'b1;
              rd_next = R_DATA;
            end else begin
              rd_next = R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (lat_cnt <= LAT_W'(1)) begin
            r_fetch = 1'b1;
            rd_next = R_DATA;
          end
        end
        R_DATA: begin
          s_axi_rvalid = 1'b1;
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              rd_next = R_IDLE;
            end else begin
              r_fetch = 1'b1;
            end
          end
        end
        default: rd_next = R_IDLE;
      endcase
    end
  end

  // Read FSM state, latency countdown and registered R beat (stable until consumed)
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state    <= R_IDLE;
      lat_cnt     <= '0;
      s_axi_rid   <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
      s_axi_rlast <= 1'b0;
    end else begin
      rd_state <= rd_next;
      if (r_start) begin
        s_axi_rid <= s_axi_arid;
        lat_cnt   <= LAT_W'(READ_LATENCY - 1);
      end else if ((rd_state == R_WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (r_fetch) begin
        if (rd_in_range && !rd_cfg_err) begin
          s_axi_rdata <= mem[rd_idx];
          s_axi_rresp <= RESP_OKAY;
        end else begin
          s_axi_rdata <= '0;
          s_axi_rresp <= RESP_SLVERR;
        end
        s_axi_rlast <= rd_last;
      end
    end
  end

endmodule

// File: tb/tb_axi_sim_mem.sv
// tb/tb_axi_sim_mem.sv - directed self-checking bench for axi_sim_mem
module tb_axi_sim_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:0]  awid = 1'b0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd3;
  logic [1:0]  awburst = 2'b01;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [0:0]  arid = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd3;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [0:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  axi_sim_mem dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awid    (awid),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awsize  (awsize),
    .s_axi_awburst (awburst),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic aw_send(input logic [0:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    chk("aw_accept", 64'(awready), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [0:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    chk("ar_accept", 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && n < 20) begin @(posedge clk); #1; n++; end
    chk("w_accept", 64'(wready), 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic b_check(input string tag, input logic [0:0] id, input logic [1:0] resp, input int hold);
    int n = 0;
    if (hold > 0) bready = 1'b0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    chk({tag, "_bid"}, 64'(bid), 64'(id));
    chk({tag, "_bresp"}, 64'(bresp), 64'(resp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_bhold_valid"}, 64'(bvalid), 64'd1);
      chk({tag, "_bhold_id"}, 64'(bid), 64'(id));
    end
    bready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_bdone"}, 64'(bvalid), 64'd0);
  endtask

  task automatic r_beat(input string tag, input logic [63:0] data, input logic [1:0] resp,
                        input logic last, input logic [0:0] id, input logic cd);
    int n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    if (cd) chk({tag, "_rdata"}, rdata, data);
    chk({tag, "_rresp"}, 64'(rresp), 64'(resp));
    chk({tag, "_rlast"}, 64'(rlast), 64'(last));
    chk({tag, "_rid"}, 64'(rid), 64'(id));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d4 [4];
    d4[0] = 64'h11; d4[1] = 64'h22; d4[2] = 64'h33; d4[3] = 64'h44;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_arready", 64'(arready), 64'd1);

    // INCR write then read back, with latency check
    aw_send(1'b0, 32'h100, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(d4[i], 8'hFF, (i == 3));
    b_check("incr_wr", 1'b0, 2'b00, 0);

    ar_send(1'b0, 32'h100, 8'd3, 2'b01);
    chk("lat_cycle1_rvalid", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    chk("lat_cycle2_rvalid", 64'(rvalid), 64'd1);
    for (int i = 0; i < 4; i++) r_beat("incr_rd", d4[i], 2'b00, (i == 3), 1'b0, 1'b1);
    chk("incr_rd_end", 64'(rvalid), 64'd0);

    // WRAP len=3 starting mid-window: 0x118,0x100,0x108,0x110
    ar_send(1'b0, 32'h118, 8'd3, 2'b10);
    r_beat("wrap0", 64'h44, 2'b00, 1'b0, 1'b0, 1'b1);
    r_beat("wrap1", 64'h11, 2'b00, 1'b0, 1'b0, 1'b1);
    r_beat("wrap2", 64'h22, 2'b00, 1'b0, 1'b0, 1'b1);
    r_beat("wrap3", 64'h33, 2'b00, 1'b1, 1'b0, 1'b1);

    // illegal WRAP length: every beat SLVERR
    ar_send(1'b0, 32'h100, 8'd2, 2'b10);
    r_beat("badwrap0", 64'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    r_beat("badwrap1", 64'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    r_beat("badwrap2", 64'h0, 2'b10, 1'b1, 1'b0, 1'b0);

    // partial strobe merge
    aw_send(1'b0, 32'h200, 8'd0, 2'b01);
    w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    b_check("strb_a", 1'b0, 2'b00, 0);
    aw_send(1'b0, 32'h200, 8'd0, 2'b01);
    w_beat(64'h0, 8'h0F, 1'b1);
    b_check("strb_b", 1'b0, 2'b00, 0);
    ar_send(1'b0, 32'h200, 8'd0, 2'b01);
    r_beat("strb_rd", 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 1'b0, 1'b1);

    // burst straddling the top of memory
    aw_send(1'b0, 32'h7FF8, 8'd1, 2'b01);
    w_beat(64'hA5A5_5A5A_0123_4567, 8'hFF, 1'b0);
    w_beat(64'h5A5A_A5A5_89AB_CDEF, 8'hFF, 1'b1);
    b_check("range_wr", 1'b0, 2'b10, 0);
    ar_send(1'b0, 32'h7FF8, 8'd1, 2'b01);
    r_beat("range_rd0", 64'hA5A5_5A5A_0123_4567, 2'b00, 1'b0, 1'b0, 1'b1);
    r_beat("range_rd1", 64'h0, 2'b10, 1'b1, 1'b0, 1'b1);

    // wlast missing on the final beat
    aw_send(1'b0, 32'h208, 8'd0, 2'b01);
    w_beat(64'h77, 8'hFF, 1'b0);
    b_check("wlast_err", 1'b0, 2'b10, 0);

    // back-pressure on B and R, ID echo
    aw_send(1'b1, 32'h300, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(64'h1000 + 64'(i), 8'hFF, (i == 3));
    b_check("stall_wr", 1'b1, 2'b00, 3);
    ar_send(1'b1, 32'h300, 8'd3, 2'b01);
    r_beat("stall_rd0", 64'h1000, 2'b00, 1'b0, 1'b1, 1'b1);
    rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold_rvalid", 64'(rvalid), 64'd1);
      chk("stall_hold_rdata", rdata, 64'h1001);
      chk("stall_hold_rlast", 64'(rlast), 64'd0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    for (int i = 1; i < 4; i++) r_beat("stall_rd", 64'h1000 + 64'(i), 2'b00, (i == 3), 1'b1, 1'b1);

    // reset in the middle of a write burst
    aw_send(1'b0, 32'h400, 8'd3, 2'b01);
    w_beat(64'hDEAD_BEEF_0000_0400, 8'hFF, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_wready", 64'(wready), 64'd0);
    chk("midrst_awready", 64'(awready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("after_rst_bvalid", 64'(bvalid), 64'd0);
    chk("after_rst_awready", 64'(awready), 64'd1);
    aw_send(1'b0, 32'h500, 8'd0, 2'b01);
    w_beat(64'h55, 8'hFF, 1'b1);
    b_check("after_rst_wr", 1'b0, 2'b00, 0);
    ar_send(1'b0, 32'h400, 8'd0, 2'b01);
    r_beat("retain_partial", 64'hDEAD_BEEF_0000_0400, 2'b00, 1'b1, 1'b0, 1'b1);
    ar_send(1'b0, 32'h100, 8'd0, 2'b01);
    r_beat("retain_old", 64'h11, 2'b00, 1'b1, 1'b0, 1'b1);
    ar_send(1'b0, 32'h500, 8'd0, 2'b01);
    r_beat("after_rst_rd", 64'h55, 2'b00, 1'b1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_sim_mem.md
Name: axi_sim_mem

Overview:
- Behavioural AXI4 slave memory for the cosim bench.
- Consumes the master port of the memory interconnect: scan DMA and rammodel backend traffic, after the 32→64 width adapter.
- Standalone, cycle-accurate alternative to the memory side of the cosim BFM. It gives deterministic latency and error responses for the EMU_SYSTEM memory path without host-side software.
- One outstanding write burst and one outstanding read burst, handled independently.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 64, data bus width; must be a power of two, at least 32.
- ID_WIDTH, 1, AXI ID width; IDs are echoed unchanged.
- MEM_WORDS, 4096, array depth in DATA_WIDTH words; valid byte range is [0, MEM_WORDS*DATA_WIDTH/8).
- READ_LATENCY, 2, cycles from AR handshake to first R beat; minimum 1.

Ports:
- clk in 1: single clock.
- rst in 1: synchronous active-high reset.
- s_axi_aw{id,addr,len,size,burst} in ID_WIDTH/ADDR_WIDTH/8/3/2: write address fields.
- s_axi_awvalid in 1 / s_axi_awready out 1: AW handshake.
- s_axi_w{data,strb,last} in DATA_WIDTH/DATA_WIDTH/8/1: write data.
- s_axi_wvalid in 1 / s_axi_wready out 1: W handshake.
- s_axi_b{id,resp} out ID_WIDTH/2: write response.
- s_axi_bvalid out 1 / s_axi_bready in 1: B handshake.
- s_axi_ar{id,addr,len,size,burst} in ID_WIDTH/ADDR_WIDTH/8/3/2: read address fields.
- s_axi_arvalid in 1 / s_axi_arready out 1: AR handshake.
- s_axi_r{id,data,resp,last} out ID_WIDTH/DATA_WIDTH/2/1: read data.
- s_axi_rvalid out 1 / s_axi_rready in 1: R handshake.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: all ready/valid outputs 0; bresp, rresp, rdata, rlast 0; both FSMs return to idle.
- Reset mid-burst abandons the burst with no B/R response. Memory contents are retained, not cleared.
- awready/arready rise in the first cycle after rst deasserts.

- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size, burst; clear beat counter and error flag.
  - W_DATA: wready=1. Each W handshake writes the strobed bytes at the current word index, then advances the address.
  - On the beat where the counter equals len, go to W_RESP.
  - wlast asserted on any other beat, or missing on the final beat, sets the error flag. The counter alone decides burst end.
  - W_RESP: bvalid=1 with bid=latched id; bresp=SLVERR (2'b10) if any error occurred, else OKAY.
  - Hold bvalid until bready, then return to W_IDLE.
- Read FSM R_IDLE → R_WAIT → R_DATA → R_IDLE:
  - R_IDLE: arready=1. On AR handshake, latch the fields and load the latency counter with READ_LATENCY-1.
  - R_WAIT: count down to 0, then go to R_DATA.
  - R_DATA: rvalid=1. rdata/rresp/rlast are held stable while rvalid && !rready.
  - On each handshake, advance the address and fetch the next word so the next beat follows with no bubble.
  - rlast=1 on beat len; its handshake returns to R_IDLE.
- Address generation, per beat:
  - FIXED: address constant.
  - INCR: address += 1<<size.
  - WRAP: wrap boundary = (len+1)<<size. Legal only for len ∈ {1,3,7,15}; any other len is treated as INCR with SLVERR.
  - Reserved burst 2'b11: handled as INCR, every beat SLVERR.
  - Word index = addr >> log2(DATA_WIDTH/8). Sub-word beats (size < bus width) use the same index; byte lanes are selected by the master's strobes.
  - 4KB boundary crossing is not checked.
- Range errors:
  - A beat outside the valid range is an error.
  - Write: the beat is dropped and the burst response is SLVERR.
  - Read: the beat returns rdata=0 with rresp=SLVERR. Later in-range beats of the same burst return OKAY.
  - awsize/arsize greater than log2(DATA_WIDTH/8) gives SLVERR for all beats; no array access.
- Read/write ordering:
  - A W handshake in cycle N is visible to any read fetch in cycle N+1 or later.
  - A read fetch in the same cycle as a write to the same word returns the old data.

Decomposition:
- Package axi_sim_mem_pkg:
  - burst constants FIXED/INCR/WRAP;
  - response constants OKAY/SLVERR;
  - write and read FSM state enums;
  - function next_addr(addr, size, len, burst).
- Sub-module axi_sim_mem_addr_gen: one instance per channel. Holds the beat counter, current address and error flag. Outputs word_idx, last, in_range.

Test Plan:
- INCR write len=3 size=3 at 0x100, data 0x11..0x44, full strobes → bresp=OKAY; INCR read of the same burst returns 0x11,0x22,0x33,0x44, rlast on beat 3 only, first rvalid exactly 2 cycles after the AR handshake.
- WRAP read len=3 size=3 at 0x118 → word addresses 0x118,0x100,0x108,0x110; len=2 WRAP → all beats SLVERR.
- Write 0xFFFF_FFFF_FFFF_FFFF, then strobe 0x0F with data 0 to the same word → read returns 0xFFFF_FFFF_0000_0000.
- INCR read len=1 straddling MEM_WORDS*8-8 → beat0 OKAY with data, beat1 rdata=0 rresp=SLVERR; write of the same span → bresp=SLVERR, beat0 stored.
- rready low for 5 cycles mid-burst, plus bready low for 3 cycles → outputs stable, no beat lost, ID echoed (awid=1 → bid=1).
- rst pulsed during W_DATA → no bvalid; next AW accepted one cycle after rst falls; previously written data still readable.
